// File: rtl/conv_code_pkg.sv
// Shared constants and helpers for the rate-1/2, K=3 convolutional code (g0 = 111, g1 = 101).
package conv_code_pkg;

  localparam int unsigned K          = 3;
  localparam int unsigned NUM_STATES = 4;
  localparam logic [2:0]  G0         = 3'b111;
  localparam logic [2:0]  G1         = 3'b101;

  typedef logic [K-2:0] state_t;

  // Encoder register is {b, s1, s0}; returns {c0, c1}.
  function automatic logic [1:0] expected_pair(input state_t state, input logic b);
    logic [K-1:0] enc_reg;
    enc_reg = {b, state};
    return {^(enc_reg & G0), ^(enc_reg & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] x);
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one next state; ties keep predecessor a (the one with s0 = 0).
module viterbi_acs
  import conv_code_pkg::*;
#(
  parameter int unsigned PM_W = 5
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [1:0]      bm_a,
  input  logic [1:0]      bm_b,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  logic [PM_W:0]   sum_a;
  logic [PM_W:0]   sum_b;
  logic [PM_W-1:0] cand_a;
  logic [PM_W-1:0] cand_b;

  always_comb begin
    sum_a  = {1'b0, pm_a} + {{(PM_W - 1){1'b0}}, bm_a};
    sum_b  = {1'b0, pm_b} + {{(PM_W - 1){1'b0}}, bm_b};
    cand_a = sum_a[PM_W] ? '1 : sum_a[PM_W-1:0];
    cand_b = sum_b[PM_W] ? '1 : sum_b[PM_W-1:0];
    dec    = (cand_b < cand_a);
    pm_new = dec ? cand_b : cand_a;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision four-state Viterbi decoder with register-exchange survivors; decoded bits
// emerge TB_DEPTH-1 accepted symbols after the symbol they belong to.
module viterbi_decoder
  import conv_code_pkg::*;
#(
  parameter int unsigned TB_DEPTH = 15,
  parameter int unsigned PM_W     = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic c0,
  input  logic c1,
  output logic out_valid,
  output logic b_hat
);

  localparam int unsigned CNT_W = $clog2(TB_DEPTH + 1);

  logic [PM_W-1:0]     pm_q   [NUM_STATES];
  logic [PM_W-1:0]     pm_d   [NUM_STATES];
  logic [PM_W-1:0]     acs_pm [NUM_STATES];
  logic [1:0]          bm     [NUM_STATES][2];
  logic [NUM_STATES-1:0] dec;
  logic [TB_DEPTH-1:0] surv_q [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_d [NUM_STATES];
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [PM_W-1:0]     min_pm;
  state_t              best;
  logic                filled;
  logic                b_hat_d;

  always_comb begin
    for (int s = 0; s < NUM_STATES; s++) begin
      for (int b = 0; b < 2; b++) begin
        bm[s][b] = hamming2(expected_pair(state_t'(s), 1'(b)) ^ {c0, c1});
      end
    end
  end

  // Next state {b, p} is reached from {p, 0} (port a) or {p, 1} (port b) with input b.
  for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
    localparam int unsigned P = ns % 2;
    localparam int unsigned B = ns / 2;
    viterbi_acs #(
      .PM_W(PM_W)
    ) u_acs (
      .pm_a  (pm_q[2*P]),
      .pm_b  (pm_q[2*P+1]),
      .bm_a  (bm[2*P][B]),
      .bm_b  (bm[2*P+1][B]),
      .pm_new(acs_pm[ns]),
      .dec   (dec[ns])
    );
  end

  always_comb begin
    state_t st;
    state_t pred;
    min_pm = acs_pm[0];
    best   = '0;
    for (int i = 1; i < NUM_STATES; i++) begin
      if (acs_pm[i] < min_pm) begin
        min_pm = acs_pm[i];
        best   = state_t'(i);
      end
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      st        = state_t'(i);
      pred      = {st[0], dec[i]};
      pm_d[i]   = acs_pm[i] - min_pm;
      surv_d[i] = (surv_q[pred] << 1) | TB_DEPTH'(st[1]);
    end
    b_hat_d = surv_d[best][TB_DEPTH-1];
    cnt_d   = (cnt_q == CNT_W'(TB_DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
    filled  = (cnt_q >= CNT_W'(TB_DEPTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_W'(4);
        surv_q[i] <= '0;
      end
      cnt_q     <= '0;
      out_valid <= 1'b0;
      b_hat     <= 1'b0;
    end else begin
      out_valid <= in_valid && filled;
      if (in_valid) begin
        pm_q   <= pm_d;
        surv_q <= surv_d;
        cnt_q  <= cnt_d;
        b_hat  <= b_hat_d;
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench: independent encoder model pushes each data bit; each decoded output pops one.
module tb_viterbi_decoder;

  localparam int unsigned D = 15;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic c0;
  logic c1;
  logic out_valid;
  logic b_hat;

  int   checks = 0;
  int   errors = 0;
  bit   sb[$];
  int   nsym;
  logic [1:0] enc_s;
  logic last_bhat;

  viterbi_decoder #(
    .TB_DEPTH(D),
    .PM_W    (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .c0       (c0),
    .c1       (c1),
    .out_valid(out_valid),
    .b_hat    (b_hat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (symbol %0d, t=%0t)", tag, got, exp, nsym, $time);
    end
  endtask

  task automatic send_pair(input logic [1:0] pair, input logic bit_v);
    logic exp;
    in_valid = 1'b1;
    c0       = pair[1];
    c1       = pair[0];
    sb.push_back(bit_v);
    nsym++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (nsym >= D) begin
      exp = sb.pop_front();
      check_eq("out_valid", out_valid, 1'b1);
      check_eq("b_hat", b_hat, exp);
    end else begin
      check_eq("out_valid_fill", out_valid, 1'b0);
    end
    last_bhat = b_hat;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_eq("gap_out_valid", out_valid, 1'b0);
      check_eq("gap_b_hat_hold", b_hat, last_bhat);
    end
  endtask

  task automatic send_bit(input logic b, input logic [1:0] err, input int gapmax);
    logic [1:0] pair;
    pair  = {b ^ enc_s[1] ^ enc_s[0], b ^ enc_s[0]} ^ err;
    enc_s = {b, enc_s[1]};
    send_pair(pair, b);
    if (gapmax > 0) gap($urandom_range(1, gapmax));
  endtask

  task automatic flush(input int n, input int gapmax);
    repeat (n) send_bit(1'b0, 2'b00, gapmax);
  endtask

  // Reset is raised mid-cycle so the asynchronous clear is visible before any edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_b_hat", b_hat, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    nsym      = 0;
    enc_s     = 2'b00;
    last_bhat = 1'b0;
  endtask

  initial begin
    bit d6[6];
    bit d8[8];
    int since_err;
    logic [1:0] err;
    d6 = '{1, 0, 1, 1, 0, 0};
    d8 = '{1, 1, 0, 1, 0, 0, 1, 0};
    in_valid = 1'b0;
    c0       = 1'b0;
    c1       = 1'b0;
    reset    = 1'b0;
    nsym     = 0;
    enc_s    = 2'b00;
    do_reset();

    // Error-free directed stream; first check of the encoder model against the given pairs.
    begin
      logic [1:0] exp_pairs[6];
      logic [1:0] s;
      exp_pairs = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
      s = 2'b00;
      for (int i = 0; i < 6; i++) begin
        logic [1:0] p;
        p = {d6[i] ^ s[1] ^ s[0], d6[i] ^ s[0]};
        if (p != exp_pairs[i]) $display("FAIL enc_model: got %b expected %b", p, exp_pairs[i]);
        s = {d6[i], s[1]};
      end
    end
    for (int i = 0; i < 6; i++) send_bit(d6[i], 2'b00, 0);
    flush(20, 0);

    // Single error: pair 3 turns 00 into 10.
    do_reset();
    for (int i = 0; i < 6; i++) send_bit(d6[i], (i == 2) ? 2'b10 : 2'b00, 0);
    flush(20, 0);

    // Gapped input.
    do_reset();
    for (int i = 0; i < 6; i++) send_bit(d6[i], 2'b00, 3);
    flush(20, 3);

    // Reset while out_valid and b_hat are both high.
    do_reset();
    repeat (D) send_bit(1'b1, 2'b00, 0);
    do_reset();

    // Reset mid-stream after symbol 8, then a fresh stream.
    for (int i = 0; i < 8; i++) send_bit(d8[(i + 3) % 8], 2'b00, 0);
    do_reset();
    for (int i = 0; i < 8; i++) send_bit(d8[i], 2'b00, 0);
    flush(20, 0);

    // Long random with isolated single-bit errors at least 10 symbols apart.
    do_reset();
    since_err = 0;
    for (int i = 0; i < 10000; i++) begin
      err = 2'b00;
      since_err++;
      if (since_err >= 10 && $urandom_range(0, 4) == 0) begin
        err       = $urandom_range(0, 1) ? 2'b10 : 2'b01;
        since_err = 0;
      end
      send_bit(1'($urandom_range(0, 1)), err, 0);
    end
    flush(2 + D - 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
